// File: rtl/div_seq_ctrl_pkg.sv
// Shared types for the iterative divider: op encoding, FSM states, decoder op mapping.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package div_seq_ctrl_pkg;

   localparam int DIV_XLEN = 32;

   // Operation carried into the divider; bit 1 set means unsigned.
   typedef enum logic [1:0] {
      DIV_S = 2'd0,
      MOD_S = 2'd1,
      DIV_U = 2'd2,
      MOD_U = 2'd3
   } div_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_e;

   // Decoder ALU op codes that steer work to the divider.
   localparam logic [4:0] ALU_DIV  = 5'h10;
   localparam logic [4:0] ALU_MOD  = 5'h11;
   localparam logic [4:0] ALU_DIVU = 5'h12;
   localparam logic [4:0] ALU_MODU = 5'h13;

   // Map a decoder ALU op onto the divider op; non-divide codes fall back to DIV_S
   // and are expected to be filtered by the decoder's valid qualifier.
   function automatic div_op_e alu_to_div_op(input logic [4:0] alu_op);
      div_op_e op;
      case (alu_op)
         ALU_DIV:  op = DIV_S;
         ALU_MOD:  op = MOD_S;
         ALU_DIVU: op = DIV_U;
         ALU_MODU: op = MOD_U;
         default:  op = DIV_S;
      endcase
      return op;
   endfunction

   function automatic logic is_signed_op(input div_op_e op);
      return (op == DIV_S) || (op == MOD_S);
   endfunction

   function automatic logic is_quot_op(input div_op_e op);
      return (op == DIV_S) || (op == DIV_U);
   endfunction

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Request/result bus between the issue stage, the divider and EX/MEM.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the request and the result side.
interface div_seq_ctrl_if
   import div_seq_ctrl_pkg::*;
#(
   parameter int XLEN = DIV_XLEN
) ();

   logic            in_valid;
   logic            in_ready;
   div_op_e         in_op;
   logic [XLEN-1:0] in_src1;
   logic [XLEN-1:0] in_src2;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_result;

   modport master (
      output in_valid, in_op, in_src1, in_src2, out_ready,
      input  in_ready, out_valid, out_result
   );

   modport slave (
      input  in_valid, in_op, in_src1, in_src2, out_ready,
      output in_ready, out_valid, out_result
   );

endinterface

// File: rtl/div_seq_ctrl_step.sv
// One radix-2 restoring division iteration on magnitudes, MSB of quo shifted into rem.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module div_seq_ctrl_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] quo_i,
   input  logic [XLEN-1:0] dvs_i,
   output logic [XLEN-1:0] rem_o,
   output logic [XLEN-1:0] quo_o
);

   logic [XLEN:0] rem_sh;
   logic [XLEN:0] diff;
   logic          ge;
   // Only a zero divisor can leave a set top bit after the step; it is shifted
   // out on purpose so rem ends up holding the dividend.
   logic          unused_top;

   // Shift, trial-subtract at XLEN+1 bits, keep the difference when it fits.
   always_comb begin
      rem_sh = {rem_i, quo_i[XLEN-1]};
      diff   = rem_sh - {1'b0, dvs_i};
      ge     = (rem_sh >= {1'b0, dvs_i});
      rem_o  = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
      quo_o  = {quo_i[XLEN-2:0], ge};
   end

   assign unused_top = diff[XLEN];

endmodule

// File: rtl/div_seq_ctrl.sv
// DIV.W/MOD.W/DIV.WU/MOD.WU sequencer: restoring division, one quotient bit per cycle.
// Latency: accept -> out_valid XLEN+1 cycles (1 cycle for a zero divisor when DIV_ZERO_BYPASS_EN is defined).
// Backpressure: result held in DONE until out_ready; no new accept until the cycle after that handshake.
module div_seq_ctrl
   import div_seq_ctrl_pkg::*;
#(
   parameter int XLEN = DIV_XLEN
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           flush,
   output logic           busy,
   div_seq_ctrl_if.slave  bus
);

   localparam int CW = $clog2(XLEN) + 1;

   div_state_e      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic            q_neg_q, q_neg_d;
   logic            r_neg_q, r_neg_d;
   div_op_e         op_q, op_d;

   logic            accept;
   logic            s1, s2;
   logic [XLEN-1:0] mag1, mag2;
   logic [XLEN-1:0] step_rem, step_quo;
   logic [XLEN-1:0] res_mag;
   logic            res_neg;

   // Operand signs only matter for signed ops; magnitudes feed the unsigned core.
   always_comb begin
      s1   = is_signed_op(bus.in_op) & bus.in_src1[XLEN-1];
      s2   = is_signed_op(bus.in_op) & bus.in_src2[XLEN-1];
      mag1 = s1 ? -bus.in_src1 : bus.in_src1;
      mag2 = s2 ? -bus.in_src2 : bus.in_src2;
   end

   assign bus.in_ready = (state_q == IDLE) & ~flush;
   assign accept       = bus.in_valid & bus.in_ready;

   div_seq_ctrl_step #(
      .XLEN (XLEN)
   ) u_step (
      .rem_i (rem_q),
      .quo_i (quo_q),
      .dvs_i (dvs_q),
      .rem_o (step_rem),
      .quo_o (step_quo)
   );

   // Next-state and datapath update; flush overrides everything back to IDLE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      op_d    = op_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               op_d    = bus.in_op;
               q_neg_d = s1 ^ s2;
               r_neg_d = s1;
               dvs_d   = mag2;
               rem_d   = '0;
               quo_d   = mag1;
               cnt_d   = '0;
               state_d = CALC;
`ifdef DIV_ZERO_BYPASS_EN
               // Same end state the iterations reach with a zero divisor:
               // all quotient bits set and the dividend shifted into rem.
               if (bus.in_src2 == '0) begin
                  quo_d   = '1;
                  rem_d   = mag1;
                  state_d = DONE;
               end
`endif
            end
         end
         CALC: begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(XLEN - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         op_q    <= DIV_S;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
         op_q    <= op_d;
      end
   end

   // Select quotient or remainder and restore the sign; forced to zero outside DONE.
   always_comb begin
      res_mag = is_quot_op(op_q) ? quo_q : rem_q;
      res_neg = is_quot_op(op_q) ? q_neg_q : r_neg_q;
   end

   assign bus.out_valid  = (state_q == DONE);
   assign bus.out_result = (state_q == DONE) ? (res_neg ? -res_mag : res_mag) : '0;
   assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl against an arithmetic reference of the defined results.
// Latency: checks XLEN+1 cycles per op (1 for zero divisor with DIV_ZERO_BYPASS_EN).
// Backpressure: exercises out_ready stalls, flush and asynchronous reset.
module tb_div_seq_ctrl;
   import div_seq_ctrl_pkg::*;

   logic clk = 1'b0;
   logic resetn;
   logic flush;
   logic busy;
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   div_seq_ctrl_if #(.XLEN(32)) bus ();

   div_seq_ctrl #(.XLEN(32)) dut (
      .clk    (clk),
      .resetn (resetn),
      .flush  (flush),
      .busy   (busy),
      .bus    (bus.slave)
   );

   // Reference: architectural results, incl. defined div-by-zero and overflow cases.
   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      sa = a;
      sb = b;
      case (op)
         2'd0: begin
            if (b == 32'd0) return a[31] ? 32'd1 : 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return sa / sb;
         end
         2'd1: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return sa % sb;
         end
         2'd2: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         default: return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_latency(input logic [31:0] b);
`ifdef DIV_ZERO_BYPASS_EN
      return (b == 32'd0) ? 1 : 33;
`else
      return (b == 32'd0) ? 33 : 33;
`endif
   endfunction

   task automatic drive_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.in_valid = 1'b1;
      bus.in_op    = div_op_e'(op);
      bus.in_src1  = a;
      bus.in_src2  = b;
   endtask

   // Called just after the accept edge; returns the cycle count to out_valid (-1 on timeout).
   task automatic wait_result(output logic [31:0] res, output int lat);
      lat = -1;
      res = '0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            lat = n;
            res = bus.out_result;
            break;
         end
      end
   endtask

   // Entered and left at #1 after a rising edge with the DUT idle.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
      drive_op(op, a, b);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      wait_result(res, lat);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_cmp++; if (bus.out_result !== 32'd0) begin n_fail++; $display("FAIL reset_out_result: got %h expected 0", bus.out_result); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
      resetn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [1:0]  vop[12];
      logic [31:0] va[12], vb[12], vexp[12];
      logic [31:0] res;
      int          lat;
      vop  = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd0, 2'd3, 2'd0};
      va   = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000,
               32'h8000_0000, 32'd5, 32'd5, 32'hFFFF_FFFB, 32'd5, 32'd5};
      vb   = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
               32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
      vexp = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000,
               32'd0, 32'hFFFF_FFFF, 32'd5, 32'd1, 32'd5, 32'hFFFF_FFFF};
      for (int i = 0; i < 12; i++) begin
         run_op(vop[i], va[i], vb[i], res, lat);
         n_cmp++;
         if (res !== vexp[i]) begin
            n_fail++;
            $display("FAIL directed_result[%0d]: got %h expected %h", i, res, vexp[i]);
         end
         n_cmp++;
         if (lat != ref_latency(vb[i])) begin
            n_fail++;
            $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, ref_latency(vb[i]));
         end
      end
   endtask

   task automatic test_random();
      logic [1:0]  op;
      logic [31:0] a, b, res;
      int          lat;
      for (int i = 0; i < 50; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: b = 32'($urandom_range(1, 15));
            3: begin a = 32'h8000_0000; b = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom; end
            4: b = -32'($urandom_range(1, 1000));
            default: b = $urandom >> $urandom_range(0, 31);
         endcase
         run_op(op, a, b, res, lat);
         n_cmp++;
         if (res !== ref_result(op, a, b)) begin
            n_fail++;
            $display("FAIL random_result[%0d] op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, res, ref_result(op, a, b));
         end
         n_cmp++;
         if (lat != ref_latency(b)) begin
            n_fail++;
            $display("FAIL random_latency[%0d]: got %0d expected %0d", i, lat, ref_latency(b));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b, res;
      int          lat;
      for (int i = 0; i < 4; i++) begin
         a = $urandom;
         b = 32'($urandom_range(1, 100000));
         run_op(2'd2, a, b, res, lat);
         n_cmp++;
         if (res !== a / b) begin n_fail++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, res, a / b); end
         n_cmp++;
         if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle[%0d]: got in_ready=%b busy=%b expected 1/0", i, bus.in_ready, busy);
         end
      end
   endtask

   task automatic test_flush();
      logic [31:0] a, b, res;
      int          lat;
      a = $urandom;
      b = 32'($urandom_range(1, 50));
      drive_op(2'd2, 32'hFFFF_FFFF, 32'd3);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      // CALC cycle 10: flush with a competing request.
      flush = 1'b1;
      drive_op(2'd1, a, b);
      @(negedge clk);
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 0", bus.in_ready); end
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before: got %b expected 1", busy); end
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle: got busy=%b expected 0", busy); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b expected 0", bus.out_valid); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready_after: got %b expected 1", bus.in_ready); end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      wait_result(res, lat);
      n_cmp++; if (res !== ref_result(2'd1, a, b)) begin n_fail++; $display("FAIL flush_new_result: got %h expected %h", res, ref_result(2'd1, a, b)); end
      n_cmp++; if (lat != 33) begin n_fail++; $display("FAIL flush_new_latency: got %0d expected 33", lat); end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      logic [31:0] res;
      int          lat;
      drive_op(2'd0, 32'hFFFF_FFF9, 32'd2);
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      wait_result(res, lat);
      n_cmp++; if (lat != 33) begin n_fail++; $display("FAIL bp_latency: got %0d expected 33", lat); end
      drive_op(2'd2, 32'd9, 32'd3);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, bus.out_valid); end
         n_cmp++; if (bus.out_result !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL bp_result[%0d]: got %h expected fffffffd", i, bus.out_result); end
         n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy[%0d]: got %b expected 1", i, busy); end
         n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL bp_release: got busy=%b out_valid=%b expected 0/0", busy, bus.out_valid);
      end
   endtask

   task automatic test_async_reset();
      logic [31:0] res;
      int          lat;
      drive_op(2'd2, 32'hDEAD_BEEF, 32'd77);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL arst_calc_busy: got %b expected 1", busy); end
      resetn = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_calc_busy_clr: got %b expected 0", busy); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_calc_out_valid: got %b expected 0", bus.out_valid); end
      @(posedge clk); #1;
      resetn = 1'b1;
      // Reset while a result is waiting in DONE.
      drive_op(2'd3, 32'd1000, 32'd7);
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      wait_result(res, lat);
      n_cmp++; if (res !== 32'd6) begin n_fail++; $display("FAIL arst_done_result: got %h expected 6", res); end
      #2;
      resetn = 1'b0;
      #1;
      n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_result !== 32'd0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL arst_done_clr: got out_valid=%b result=%h busy=%b expected 0/0/0", bus.out_valid, bus.out_result, busy);
      end
      @(posedge clk); #1;
      resetn = 1'b1;
      run_op(2'd0, 32'd100, 32'hFFFF_FFF9, res, lat);
      n_cmp++; if (res !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL arst_recover: got %h expected fffffff2", res); end
   endtask

   initial begin
      resetn        = 1'b0;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_op     = DIV_S;
      bus.in_src1   = '0;
      bus.in_src2   = '0;
      bus.out_ready = 1'b1;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_flush();
      test_backpressure();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, %0d compared so far", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
